// File: rtl/memory_stage_pkg.sv
// Shared encodings for the RV32I memory stage: funct3 load/store codes,
// writeback result-source codes and the bus-access state type.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_t;

  // Stores only have signed-looking encodings; the unsigned ones are loads only.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Combinational load/store lane steering: byte enables, replicated store data,
// load extraction with sign/zero extension, and fault (illegal/misaligned) detect.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [31:0] shifted_s;
  logic        misalign_s;

  // Lane steering and extension selected by access size (funct3[1:0])
  always_comb begin
    shifted_s  = rdata >> {addr_lo, 3'b000};
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = rdata;
    misalign_s = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'h000000, shifted_s[7:0]}
                              : {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'h0000, shifted_s[15:0]}
                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
        misalign_s = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misalign_s = |addr_lo;
      end
      default: begin
        be         = 4'b0000;
        wdata      = store_data;
        load_data  = rdata;
        misalign_s = 1'b0;
      end
    endcase
    fault = misalign_s | ~f3_legal(is_store, funct3);
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: EX/MEM register, data-bus access FSM with front-end stall,
// MEM/WB register and M-stage forwarding outputs.
module memory_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            misaligned,
  output logic [XLEN-1:0] ALUResultM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
);

  logic            reg_write_m_r, mem_write_m_r;
  logic [1:0]      result_src_m_r;
  logic [2:0]      funct3_m_r;
  logic [XLEN-1:0] alu_result_m_r, write_data_m_r, pc_plus4_m_r;
  logic [4:0]      rd_m_r;
  mem_state_t      state_r;

  logic            reg_write_w_r;
  logic [1:0]      result_src_w_r;
  logic [4:0]      rd_w_r;
  logic [XLEN-1:0] alu_result_w_r, read_data_w_r, pc_plus4_w_r;

  logic            access_s, fault_s, bad_s, req_s, done_s, stall_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s, load_data_s;

  lsu_align u_align (
    .is_store   (mem_write_m_r),
    .funct3     (funct3_m_r),
    .addr_lo    (alu_result_m_r[1:0]),
    .store_data (write_data_m_r),
    .rdata      (dmem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s),
    .fault      (fault_s)
  );

  // Request generation and completion; a store completes in its accept cycle,
  // a load only on the response beat
  always_comb begin
    access_s = mem_write_m_r | (result_src_m_r == RES_LOAD);
    bad_s    = access_s & fault_s;
    req_s    = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        req_s  = access_s & ~bad_s & rst_n;
        done_s = req_s & mem_write_m_r & dmem_ready;
      end
      RESP: begin
        req_s  = 1'b0;
        done_s = dmem_rvalid;
      end
      default: begin
        req_s  = 1'b0;
        done_s = 1'b0;
      end
    endcase
    stall_s = access_s & ~bad_s & ~done_s;
  end

  assign dmem_req   = req_s;
  assign dmem_we    = req_s & mem_write_m_r;
  assign dmem_addr  = {alu_result_m_r[XLEN-1:2], 2'b00};
  assign dmem_be    = req_s ? be_s : 4'b0000;
  assign dmem_wdata = wdata_s;
  assign mem_stall  = stall_s;
  assign misaligned = bad_s;
  assign ALUResultM = alu_result_m_r;
  assign RdM        = rd_m_r;
  assign RegWriteM  = reg_write_m_r;
  assign RegWriteW  = reg_write_w_r;
  assign ResultSrcW = result_src_w_r;
  assign RdW        = rd_w_r;
  assign ALUResultW = alu_result_w_r;
  assign ReadDataW  = read_data_w_r;
  assign PCPlus4W   = pc_plus4_w_r;

  // EX/MEM register: frozen while the current access is outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_m_r  <= 1'b0;
      result_src_m_r <= RES_ALU;
      mem_write_m_r  <= 1'b0;
      funct3_m_r     <= 3'b000;
      alu_result_m_r <= '0;
      write_data_m_r <= '0;
      pc_plus4_m_r   <= '0;
      rd_m_r         <= 5'd0;
    end else if (!stall_s) begin
      reg_write_m_r  <= RegWriteE;
      result_src_m_r <= ResultSrcE;
      mem_write_m_r  <= MemWriteE;
      funct3_m_r     <= funct3E;
      alu_result_m_r <= ALUResultE;
      write_data_m_r <= WriteDataE;
      pc_plus4_m_r   <= PCPlus4E;
      rd_m_r         <= RdE;
    end
  end

  // Bus FSM: only an accepted load waits for a response beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    if (req_s && dmem_ready && !mem_write_m_r) state_r <= RESP;
        RESP:    if (dmem_rvalid) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // MEM/WB register: stalled or faulting ops leave a bubble behind
  always_ff @(posedge clk) begin
    if (!rst_n || stall_s || bad_s) begin
      reg_write_w_r  <= 1'b0;
      result_src_w_r <= RES_ALU;
      rd_w_r         <= 5'd0;
      alu_result_w_r <= '0;
      read_data_w_r  <= '0;
      pc_plus4_w_r   <= '0;
    end else begin
      reg_write_w_r  <= reg_write_m_r;
      result_src_w_r <= result_src_m_r;
      rd_w_r         <= rd_m_r;
      alu_result_w_r <= alu_result_m_r;
      read_data_w_r  <= load_data_s;
      pc_plus4_w_r   <= pc_plus4_m_r;
    end
  end

endmodule
